// File: rtl/wb_sid_sequencer.sv
`timescale 1ns/1ps
// wb_sid_sequencer: Wishbone write master that plays queued SID register
// writes, waiting a per-command number of prescaled ticks after each write.
// Optional feature macro: SEQ_TIMEOUT_EN (abort a write that sees no ack
// within MAX_WAIT cycles and flag timeout_err).
// Handshake: a command is accepted on every rising clk_i edge where
// cmd_valid && cmd_ready; cmd_ready is derived only from the registered fill
// level, so it never depends on cmd_valid in the same cycle.
module wb_sid_sequencer #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       DATA_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = 16'h0100,
  parameter int                       FIFO_DEPTH    = 8,
  parameter int                       TICK_DIV      = 12000,
  parameter int                       MAX_WAIT      = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [4:0]                      cmd_reg,
  input  logic [DATA_WIDTH-1:0]           cmd_data,
  input  logic [7:0]                      cmd_delay,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  output logic [ADDRESS_WIDTH-1:0]        adr_o,
  output logic [DATA_WIDTH-1:0]           dat_o,
  input  logic [DATA_WIDTH-1:0]           dat_i,
  output logic                            we_o,
  output logic                            sel_o,
  output logic                            stb_o,
  output logic                            cyc_o,
  input  logic                            cyc_i,
  input  logic                            ack_i,
  output logic [2:0]                      cti_o,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            timeout_err,
  input  logic                            err_clr,
  output logic [1:0]                      state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 5 + DATA_WIDTH + 8;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    WRITE    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic                  push, pop;

  logic [4:0]            cur_reg;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [7:0]            cur_delay;
  logic [7:0]            delay_cnt;
  logic                  load_delay;

  logic [PW-1:0]         presc;
  logic                  tick;

`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0]         wait_cnt;
  logic                  timeout_hit;
`endif

  // Read data is never used by a write-only master; err_clr is idle without the timeout.
  logic unused_inputs;
  assign unused_inputs = ^{dat_i, err_clr};

  assign push      = cmd_valid && cmd_ready;
  assign cmd_ready = (level != LW'(FIFO_DEPTH));

  // Command storage; no reset needed, validity is tracked by level.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {cmd_reg, cmd_data, cmd_delay};
  end

  // FIFO pointers and fill level; push+pop in one cycle leaves level unchanged.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Latch the head command when it leaves the FIFO; it stays put for retries.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cur_reg   <= '0;
      cur_data  <= '0;
      cur_delay <= '0;
    end else if (pop) begin
      {cur_reg, cur_data, cur_delay} <= mem[rd_ptr];
    end
  end

  // Free-running tick prescaler, one-cycle tick at the wrap.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Post-write delay counter, counted down in ticks while holding.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                             delay_cnt <= '0;
    else if (load_delay)                    delay_cnt <= cur_delay;
    else if (state == HOLD && tick && delay_cnt != 8'd0) delay_cnt <= delay_cnt - 8'd1;
  end

`ifdef SEQ_TIMEOUT_EN
  // Cycles spent in WRITE without ack; restarts on every entry to WRITE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                    wait_cnt <= '0;
    else if (state == WRITE && state_next == WRITE) wait_cnt <= wait_cnt + 1'b1;
    else                                           wait_cnt <= '0;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)           timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (err_clr)     timeout_err <= 1'b0;
  end
`else
  assign timeout_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_delay = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          state_next = WAIT_BUS;
        end
      end
      WAIT_BUS: begin
        if (!cyc_i) state_next = WRITE;
      end
      WRITE: begin
        if (ack_i) begin
          if (cur_delay != 8'd0) begin
            load_delay = 1'b1;
            state_next = HOLD;
          end else begin
            state_next = IDLE;
          end
        end else if (cyc_i) begin
          // Lost arbitration: release the bus and retry the same command.
          state_next = WAIT_BUS;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
`endif
      end
      HOLD: begin
        if (tick && delay_cnt <= 8'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs follow the registered state, so they are glitch-free and
  // drop together with an asynchronous reset.
  assign cyc_o      = (state == WRITE);
  assign stb_o      = cyc_o;
  assign we_o       = cyc_o;
  assign sel_o      = cyc_o;
  assign cti_o      = 3'b000;
  assign adr_o      = cyc_o ? (BASE_ADDRESS + ADDRESS_WIDTH'(cur_reg)) : '0;
  assign dat_o      = cyc_o ? cur_data : '0;
  assign busy       = (state != IDLE) || (level != '0);
  assign fifo_level = level;
  assign state_dbg  = state;

endmodule

// File: tb/tb_wb_sid_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for wb_sid_sequencer (TICK_DIV shortened to 4).
module tb_wb_sid_sequencer;

  localparam int          TD   = 4;
  localparam logic [15:0] BASE = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  cmd_reg = '0;
  logic [7:0]  cmd_data = '0;
  logic [7:0]  cmd_delay = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] adr_o;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i = 8'h5C;
  logic        we_o, sel_o, stb_o, cyc_o;
  logic        cyc_i = 1'b0;
  logic        ack_i;
  logic [2:0]  cti_o;
  logic        busy;
  logic [3:0]  fifo_level;
  logic        timeout_err;
  logic        err_clr = 1'b0;
  logic [1:0]  state_dbg;
  logic        ack_en = 1'b1;

  wb_sid_sequencer #(.TICK_DIV(TD)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .cmd_delay(cmd_delay), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .cyc_i(cyc_i), .ack_i(ack_i), .cti_o(cti_o),
    .busy(busy), .fifo_level(fifo_level), .timeout_err(timeout_err),
    .err_clr(err_clr), .state_dbg(state_dbg)
  );

  // ---------------- clock / slave ----------------
  always #5 clk = ~clk;
  assign ack_i = ack_en && stb_o;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;
  int t = 0;
  int ack_count = 0;
  int have_prev = 0;
  int prev_a = 0;
  int prev_d = 0;
  bit timing_en = 1'b0;
  logic        stb_prev = 1'b0;
  logic [23:0] wr_prev = '0;
  logic [23:0] exp_q[$];
  int          push_t_q[$];
  int          dly_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, t);
  endtask

  task automatic chk_range(input string name, input int val, input int lo, input int hi);
    checks++;
    if (val >= lo && val <= hi) passes++;
    else $display("FAIL %s: actual %0d required %0d..%0d (cycle %0d)", name, val, lo, hi, t);
  endtask

  // Hold time after an acked write, in cycles: delay-1..delay ticks, at least one cycle.
  function automatic int hold_min(input int d);
    return (d == 0) ? 0 : (d - 1) * TD + 1;
  endfunction
  function automatic int hold_max(input int d);
    return d * TD;
  endfunction

  // ---------------- scoreboard / monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    int lo, hi;
    logic [15:0] a;
    t = t + 1;
    if (!rst_i) begin
      exp_q.delete();
      push_t_q.delete();
      dly_q.delete();
      have_prev = 0;
      stb_prev  = 1'b0;
    end else begin
      if (!cyc_o) chk("idle_bus_zero", {8'd0, adr_o, dat_o}, 32'd0);
      if (stb_o && stb_prev) chk("stb_stable", {8'd0, adr_o, dat_o}, {8'd0, wr_prev});
      // Write start: no earlier than both the previous write's hold and the push allow.
      if (stb_o && !stb_prev && timing_en && push_t_q.size() != 0) begin
        lo = push_t_q[0];
        hi = push_t_q[0];
        if (have_prev != 0 && prev_a + hold_min(prev_d) > lo) lo = prev_a + hold_min(prev_d);
        if (have_prev != 0 && prev_a + hold_max(prev_d) > hi) hi = prev_a + hold_max(prev_d);
        chk_range("write_start_cycle", t, lo + 3, hi + 3);
      end
      if (stb_o && ack_i) begin
        ack_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {8'd0, adr_o, dat_o}, 32'hFFFF_FFFF);
        end else begin
          chk("wb_write", {8'd0, adr_o, dat_o}, {8'd0, exp_q.pop_front()});
          void'(push_t_q.pop_front());
          prev_d    = dly_q.pop_front();
          prev_a    = t;
          have_prev = 1;
        end
      end
      if (cmd_valid && cmd_ready) begin
        a = BASE + {11'd0, cmd_reg};
        exp_q.push_back({a, cmd_data});
        push_t_q.push_back(t);
        dly_q.push_back(int'(cmd_delay));
      end
      stb_prev = stb_o;
      wr_prev  = {adr_o, dat_o};
    end
  end

  // ---------------- driver tasks (enter and leave just after a rising edge) ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_cmd(input logic [4:0] r, input logic [7:0] d, input logic [7:0] dl);
    bit acc = 1'b0;
    cmd_reg = r; cmd_data = d; cmd_delay = dl; cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("push_accepted", 32'd0, 32'd1);
  endtask

  task automatic wait_stb(output int ts);
    bit got = 1'b0;
    ts = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stb_o) begin got = 1'b1; ts = t; end
      @(posedge clk); #1;
      if (got) break;
    end
    chk("stb_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_ack(output logic [15:0] a, output logic [7:0] d,
                          output logic [1:0] ws, output int ta);
    bit got = 1'b0;
    a = '0; d = '0; ws = '0; ta = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stb_o && ack_i) begin got = 1'b1; a = adr_o; d = dat_o; ws = {we_o, sel_o}; ta = t; end
      @(posedge clk); #1;
      if (got) break;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    step(2);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [4:0]  r;
    logic [7:0]  d;
    logic [7:0]  dl;
    logic [15:0] exp_adr;
    logic [7:0]  exp_dat;
  } vec_t;
  vec_t vecs[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] a;
    logic [7:0]  d;
    logic [1:0]  ws;
    int ta, ts, base_acks, n;

    vecs[0] = '{5'd4,  8'h41, 8'd0, 16'h0104, 8'h41};
    vecs[1] = '{5'd0,  8'h00, 8'd0, 16'h0100, 8'h00};
    vecs[2] = '{5'd31, 8'hFF, 8'd0, 16'h011F, 8'hFF};
    vecs[3] = '{5'd16, 8'hA5, 8'd1, 16'h0110, 8'hA5};
    vecs[4] = '{5'd1,  8'h5A, 8'd0, 16'h0101, 8'h5A};
    vecs[5] = '{5'd15, 8'h3C, 8'd2, 16'h010F, 8'h3C};

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_cyc", {31'd0, cyc_o}, 32'd0);
    chk("rst_stb_we", {30'd0, stb_o, we_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_cti", {29'd0, cti_o}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Latency: push in cycle 0, strobe in cycle 3 only, low again in cycle 4
    push_cmd(5'd4, 8'h41, 8'd0);
    @(negedge clk); chk("lat_c1_stb", {31'd0, stb_o}, 32'd0);
    @(negedge clk); chk("lat_c2_stb", {31'd0, stb_o}, 32'd0);
    @(negedge clk);
    chk("lat_c3_stb_cyc_we_sel", {28'd0, stb_o, cyc_o, we_o, sel_o}, 32'hF);
    chk("lat_c3_adr", {16'd0, adr_o}, 32'h0104);
    chk("lat_c3_dat", {24'd0, dat_o}, 32'h41);
    @(negedge clk); chk("lat_c4_cyc", {31'd0, cyc_o}, 32'd0);
    @(posedge clk); #1;
    step(2);

    // Table-driven single writes
    foreach (vecs[i]) begin
      push_cmd(vecs[i].r, vecs[i].d, vecs[i].dl);
      wait_ack(a, d, ws, ta);
      chk("vec_adr", {16'd0, a}, {16'd0, vecs[i].exp_adr});
      chk("vec_dat", {24'd0, d}, {24'd0, vecs[i].exp_dat});
      chk("vec_we_sel", {30'd0, ws}, 32'd3);
      @(negedge clk); chk("vec_cyc_drop", {31'd0, cyc_o}, 32'd0);
      @(posedge clk); #1;
      step(int'(vecs[i].dl) * TD + 2);
    end

    // Delay of 2 ticks between two queued writes
    push_cmd(5'd0, 8'h10, 8'd2);
    push_cmd(5'd1, 8'h20, 8'd0);
    wait_ack(a, d, ws, ta);
    wait_stb(ts);
    chk_range("delay2_gap", ts - 1 - ta, 5, 10);
    drain(50);

    // Bus busy for 10 cycles: no request until it frees, then one cycle later
    cyc_i = 1'b1;
    push_cmd(5'd3, 8'h33, 8'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("busbusy_cyc_low", {31'd0, cyc_o}, 32'd0);
      @(posedge clk); #1;
    end
    cyc_i = 1'b0;
    @(negedge clk); chk("busfree_c0_stb", {31'd0, stb_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("busfree_c1_stb", {31'd0, stb_o}, 32'd1);
    @(posedge clk); #1;
    drain(50);

    // Lost arbitration mid-write: retried, one acked write
    base_acks = ack_count;
    ack_en = 1'b0;
    push_cmd(5'd7, 8'h77, 8'd0);
    wait_stb(ts);
    cyc_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("arb_drop_cyc", {31'd0, cyc_o}, 32'd0);
    @(posedge clk); #1;
    cyc_i = 1'b0;
    ack_en = 1'b1;
    drain(50);
    chk("arb_single_ack", ack_count - base_acks, 32'd1);

`ifndef SEQ_TIMEOUT_EN
    // Nine commands with no ack: 8 held plus 1 in flight, then drain in order
    base_acks = ack_count;
    ack_en = 1'b0;
    for (int i = 0; i < 9; i++) push_cmd(5'(i + 8), 8'(8'hC0 + i), 8'd0);
    @(negedge clk);
    chk("full_level", {28'd0, fifo_level}, 32'd8);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    cmd_reg = 5'd30; cmd_data = 8'hEE; cmd_valid = 1'b1;
    step(3);
    cmd_valid = 1'b0;
    @(negedge clk); chk("full_level_hold", {28'd0, fifo_level}, 32'd8);
    @(posedge clk); #1;
    ack_en = 1'b1;
    drain(100);
    chk("full_nine_acks", ack_count - base_acks, 32'd9);
    @(negedge clk);
    chk("full_idle_busy", {31'd0, busy}, 32'd0);
    chk("no_timeout_flag", {31'd0, timeout_err}, 32'd0);
    @(posedge clk); #1;
`else
    // Write never acked: abandoned after MAX_WAIT cycles, flag set, next command proceeds
    ack_en = 1'b0;
    push_cmd(5'd2, 8'hE2, 8'd0);
    wait_stb(ts);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stb_o) n++;
      @(posedge clk); #1;
      if (!stb_o) break;
    end
    chk("timeout_stb_cycles", n, 32'd8);
    chk("timeout_flag_set", {31'd0, timeout_err}, 32'd1);
    void'(exp_q.pop_front()); void'(push_t_q.pop_front()); void'(dly_q.pop_front());
    ack_en = 1'b1;
    push_cmd(5'd5, 8'h55, 8'd0);
    drain(50);
    chk("timeout_flag_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    @(negedge clk); chk("timeout_flag_clr", {31'd0, timeout_err}, 32'd0);
    @(posedge clk); #1;
`endif

    // Reset asserted mid-write: bus drops at once, FIFO empty afterwards
    ack_en = 1'b0;
    push_cmd(5'd9, 8'h99, 8'd0);
    push_cmd(5'd10, 8'h9A, 8'd0);
    wait_stb(ts);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rstmid_bus", {29'd0, cyc_o, stb_o, we_o}, 32'd0);
    chk("rstmid_level", {28'd0, fifo_level}, 32'd0);
    @(posedge clk); #1;
    step(1);
    rst_i = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    step(5);

    // Random commands against the timing and ordering model
    base_acks = ack_count;
    timing_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 3));
      push_cmd(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 3)));
    end
    drain(2000);
    timing_en = 1'b0;
    chk("rand_ack_count", ack_count - base_acks, 32'd40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
